// File: rtl/microcode_pkg.sv
// Shared microcode constants: microinstruction addresses, opcodes and the
// dispatch-table interface types. Imported by the sequencer and the ROM.
package microcode_pkg;

  // Microinstruction addresses (4-bit ROM address space, 10 used).
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    JEX     = 4'd9
  } state_e;

  // IR[31:26] encodings understood by the control unit.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Which dispatch table a lookup uses.
  typedef enum logic {
    TBL_DECODE = 1'b0,
    TBL_MEMADR = 1'b1
  } tbl_sel_e;

  // Result of a dispatch lookup; target is FETCH whenever valid is low.
  typedef struct packed {
    logic [3:0] target;
    logic       valid;
  } dispatch_t;

endpackage

// File: rtl/microsequencer_dispatch.sv
// Combinational dispatch ROMs: maps (opcode, table) to {target, valid}.
// Table 1 is used from DECODE, table 2 from MEMADR.
module microsequencer_dispatch
  import microcode_pkg::*;
(
  input  logic [5:0] opcode,
  input  tbl_sel_e   sel,
  output dispatch_t  result
);

  // Table lookup; an unmatched opcode returns FETCH with valid low.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    result.target = FETCH;
    result.valid  = 1'b0;
    if (sel == TBL_DECODE) begin
      unique case (opcode)
        OP_RTYPE:     begin result.target = RTYPEEX; result.valid = 1'b1; end
        OP_LW, OP_SW: begin result.target = MEMADR;  result.valid = 1'b1; end
        OP_BEQ:       begin result.target = BEQEX;   result.valid = 1'b1; end
        OP_J:         begin result.target = JEX;     result.valid = 1'b1; end
        default:      ;
      endcase
    end else begin
      unique case (opcode)
        OP_LW:   begin result.target = MEMRD; result.valid = 1'b1; end
        OP_SW:   begin result.target = MEMWR; result.valid = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Next-state engine of the multicycle MIPS control unit: state register,
// priority mux (reset > stall > increment > dispatch/return), sticky
// illegal-opcode flag and retired-instruction counter.
// Optional: define MICROSEQ_PERF_EN to build the instr_count counter;
// otherwise instr_count is tied to zero.
module microsequencer
  import microcode_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               addrctl,
  input  logic               stall,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  // Plain 4-bit register rather than state_e so upset values 10..15 are representable.
  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       illegal_q;
  logic       take_illegal;
  tbl_sel_e   tbl_sel;
  dispatch_t  disp;

  microsequencer_dispatch u_dispatch (
    .opcode (opcode),
    .sel    (tbl_sel),
    .result (disp)
  );

  // Next-state selection and illegal-path detection.
  always_comb begin
    next_state   = state_q;
    take_illegal = 1'b0;
    tbl_sel      = (state_q == MEMADR) ? TBL_MEMADR : TBL_DECODE;
    if (!stall) begin
      if (state_q > JEX) begin
        next_state = FETCH;                       // recover from an out-of-range address
      end else if (addrctl) begin
        next_state = (state_q == JEX) ? FETCH : state_q + 4'd1;
      end else if (state_q == DECODE || state_q == MEMADR) begin
        next_state   = disp.target;               // FETCH when the lookup misses
        take_illegal = (state_q == DECODE) && !disp.valid;
      end else begin
        next_state = FETCH;
      end
    end
  end

  // State register and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= next_state;
      if (take_illegal) illegal_q <= 1'b1;
    end
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

`ifdef MICROSEQ_PERF_EN
  logic [COUNT_W-1:0] count_q;

  // Count each FETCH->DECODE load; wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (state_q == FETCH && next_state == DECODE) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer: reset, every dispatch
// path, illegal opcode, stalls, JEX increment and out-of-range recovery.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        addrctl;
  logic        stall;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  microsequencer #(.COUNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .addrctl     (addrctl),
    .stall       (stall),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, sample 1 time unit later.
  task automatic tick(input logic a, input logic s);
    addrctl = a;
    stall   = s;
    @(posedge clk);
    #1;
  endtask

  // One unstalled edge followed by a state comparison.
  task automatic step(input logic a, input logic [3:0] exp, input string tag);
    tick(a, 1'b0);
    check(tag, 64'(state), 64'(exp));
  endtask

  task automatic check_count(input string tag);
`ifdef MICROSEQ_PERF_EN
    check(tag, 64'(instr_count), 64'(exp_cnt));
`else
    check(tag, 64'(instr_count), 64'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b000000; addrctl = 1'b0; stall = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);
    check_count("rst_count");
    reset = 1'b0;

    // lw: addrctl 1,0,0,1,0 -> 1,2,3,4,0
    opcode = 6'b100011;
    step(1'b1, 4'd1, "lw_decode"); exp_cnt++;
    step(1'b0, 4'd2, "lw_memadr");
    step(1'b0, 4'd3, "lw_memrd");
    step(1'b1, 4'd4, "lw_memwb");
    step(1'b0, 4'd0, "lw_fetch");
    check_count("lw_count");

    // sw: 1,2,5,0
    opcode = 6'b101011;
    step(1'b1, 4'd1, "sw_decode"); exp_cnt++;
    step(1'b0, 4'd2, "sw_memadr");
    step(1'b0, 4'd5, "sw_memwr");
    step(1'b0, 4'd0, "sw_fetch");
    // R-type: 1,6,7,0
    opcode = 6'b000000;
    step(1'b1, 4'd1, "rt_decode"); exp_cnt++;
    step(1'b0, 4'd6, "rt_ex");
    step(1'b1, 4'd7, "rt_wb");
    step(1'b0, 4'd0, "rt_fetch");
    // beq: 1,8,0
    opcode = 6'b000100;
    step(1'b1, 4'd1, "beq_decode"); exp_cnt++;
    step(1'b0, 4'd8, "beq_ex");
    step(1'b0, 4'd0, "beq_fetch");
    // j: 1,9,0
    opcode = 6'b000010;
    step(1'b1, 4'd1, "j_decode"); exp_cnt++;
    step(1'b0, 4'd9, "j_ex");
    step(1'b0, 4'd0, "j_fetch");
    check_count("dispatch_count");
    check("no_illegal_yet", 64'(illegal_op), 64'd0);

    // Illegal opcode: DECODE -> FETCH, flag sets and stays set.
    opcode = 6'b111111;
    step(1'b1, 4'd1, "ill_decode"); exp_cnt++;
    check("ill_flag_pre", 64'(illegal_op), 64'd0);
    step(1'b0, 4'd0, "ill_fetch");
    check("ill_flag_set", 64'(illegal_op), 64'd1);
    opcode = 6'b000000;
    step(1'b1, 4'd1, "ill_rt_decode"); exp_cnt++;
    step(1'b0, 4'd6, "ill_rt_ex");
    step(1'b1, 4'd7, "ill_rt_wb");
    step(1'b0, 4'd0, "ill_rt_fetch");
    check("ill_flag_sticky", 64'(illegal_op), 64'd1);

    // Illegal opcode in MEMADR table: FETCH without touching the flag path.
    // (opcode 000000 reaching MEMADR via increment from DECODE)
    step(1'b1, 4'd1, "t2_decode"); exp_cnt++;
    step(1'b1, 4'd2, "t2_memadr");
    step(1'b0, 4'd0, "t2_miss_fetch");

    // Stall 3 cycles in DECODE: hold at 1, count once.
    step(1'b1, 4'd1, "st_decode"); exp_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      check("st_hold", 64'(state), 64'd1);
    end
    check_count("st_count");
    step(1'b0, 4'd6, "st_ex");
    step(1'b1, 4'd7, "st_wb");
    step(1'b0, 4'd0, "st_fetch");
    check_count("st_count_after");

    // addrctl=1 in JEX returns to FETCH.
    opcode = 6'b000010;
    step(1'b1, 4'd1, "jx_decode"); exp_cnt++;
    step(1'b0, 4'd9, "jx_ex");
    step(1'b1, 4'd0, "jx_inc_fetch");

    // Out-of-range state: upset DECODE into 12, recover to FETCH.
    step(1'b1, 4'd1, "up_decode"); exp_cnt++;
    force dut.state_q = 4'd12;
    #1;
    release dut.state_q;
    #1;
    check("up_forced", 64'(state), 64'd12);
    step(1'b1, 4'd0, "up_recover");
    check_count("up_count");

    // Reset mid-RTYPEEX with stall high, held for two edges.
    opcode = 6'b000000;
    step(1'b1, 4'd1, "rr_decode"); exp_cnt++;
    step(1'b0, 4'd6, "rr_ex");
    reset = 1'b1;
    tick(1'b0, 1'b1);
    exp_cnt = 0;
    check("rr_state", 64'(state), 64'd0);
    check("rr_illegal", 64'(illegal_op), 64'd0);
    check_count("rr_count");
    tick(1'b0, 1'b1);
    check("rr_state2", 64'(state), 64'd0);
    reset = 1'b0;
    step(1'b1, 4'd1, "post_decode"); exp_cnt++;
    check_count("post_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state engine for the multicycle MIPS control unit. It drives the 4-bit `state` address into the microprogram ROM. It consumes the ROM's `addrctl` bit and the instruction opcode, and selects the next microinstruction address by one of three rules: sequential increment, dispatch, or return to FETCH. It sits between the instruction register and the microprogram ROM and closes the control loop.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26] of the current instruction.
- `addrctl`  in  1  from the microprogram ROM. 1 = next sequential address; 0 = dispatch/return.
- `stall`  in  1  holds the current state; memory wait.
- `state`  out  4  current microinstruction address to the ROM.
- `illegal_op`  out  1  sticky flag, set on an undecodable opcode in DECODE.
- `instr_count`  out  COUNT_W  number of instructions entering DECODE.

## Operation
- States:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMRD
  - 4 MEMWB
  - 5 MEMWR
  - 6 RTYPEEX
  - 7 RTYPEWB
  - 8 BEQEX
  - 9 JEX
- Next-state priority, highest first:
  - `reset` → FETCH.
  - `stall` → hold.
  - `addrctl`=1 → state+1.
  - `addrctl`=0 → dispatch/return rules below.
- `addrctl`=0 in DECODE, dispatch table 1:
  - 000000 → RTYPEEX.
  - 100011 and 101011 → MEMADR.
  - 000100 → BEQEX.
  - 000010 → JEX.
  - Any other opcode → FETCH, and `illegal_op` is set.
- `addrctl`=0 in MEMADR, dispatch table 2:
  - 100011 → MEMRD.
  - 101011 → MEMWR.
  - Other → FETCH; no flag, since the opcode was already checked in DECODE.
- `addrctl`=0 in any other state → FETCH.
- `addrctl`=1 in state 9 or higher → FETCH. The increment never leaves the legal range.
- State register holding 10–15 (for example after an upset) → FETCH on the next unstalled edge, regardless of `addrctl`.
- `illegal_op` behaviour:
  - Sets on the edge that leaves DECODE via the illegal path.
  - Stays set until `reset`.
  - It does not block execution; the next instruction is fetched normally.
- `instr_count` increments on every edge where the state register loads DECODE from FETCH. It does not increment while stalled in DECODE. It wraps modulo 2^COUNT_W.

## Timing
- Reset values:
  - `state` = 0 (FETCH).
  - `illegal_op` = 0.
  - `instr_count` = 0.
- All outputs are registered. `state` changes exactly one edge after the inputs that select it.
- The next-state logic is combinational on `state`, `addrctl`, `opcode` and `stall`. `opcode` must be stable in DECODE and MEMADR, because IR is written only in FETCH.
- Instruction lengths with no stalls, counted in edges from FETCH to the next FETCH:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - j: 3.
  - Illegal opcode: 2.
- Each stall cycle adds one cycle to the instruction.
- `reset` in any state, including while `stall` is high, forces FETCH on that edge. It also clears the flag and the counter.

## Configuration
- Macro `MICROSEQ_PERF_EN`.
- Defined: the `instr_count` register and its increment logic are built.
- Undefined: the port remains, `instr_count` is tied to all zeros, and no counter flops are synthesized.
- Next-state behaviour and `illegal_op` are identical in both builds.

## Structure
- Shared package `microcode_pkg` holds:
  - The 4-bit state constants FETCH..JEX.
  - The opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
- The microprogram ROM imports the same constants.
- One sub-module, `microsequencer_dispatch`:
  - Purely combinational.
  - Maps (`opcode`, table select) to {target state, valid}.
  - Holds dispatch tables 1 and 2.
- The top level holds the state register, the priority mux, the flag and the counter.

## Test plan
- **Reset:** hold `reset` for 2 cycles mid-RTYPEEX with `stall`=1 → `state`=0, `illegal_op`=0 and `instr_count`=0 on the first reset edge.
- **lw:** opcode 100011 with the ROM `addrctl` sequence 1,0,0,1,0 → states 0,1,2,3,4,0; `instr_count`=1.
- **Dispatch:** opcode 101011, then 000000, then 000100, then 000010 → paths 0,1,2,5,0 / 0,1,6,7,0 / 0,1,8,0 / 0,1,9,0; `instr_count`=4.
- **Illegal opcode:** opcode 111111 in DECODE with `addrctl`=0 → next state 0 and `illegal_op`=1. The flag stays 1 through a following legal R-type and clears only on `reset`.
- **Stall:** assert `stall` for 3 cycles in DECODE → `state` holds at 1 for 3 extra cycles and `instr_count` increments only once. With the macro undefined, `instr_count` stays 0.
- **Illegal state:** force the state register to 12 with `addrctl`=1 → `state`=0 next edge. Also: `addrctl`=1 in JEX → `state`=0.
